// File: rtl/uart_rx_frame_pkg.sv
// Shared UART receiver definitions: FIFO word layout, FSM encoding
// and the parity helper used by the frame receiver.
package uart_defines;

   localparam int UART_FIFO_REC_WIDTH = 11;

   localparam int RF_BI       = 0;
   localparam int RF_FE       = 1;
   localparam int RF_PE       = 2;
   localparam int RF_CHAR_LSB = 3;

   localparam int LCR_PEN = 3;
   localparam int LCR_EPS = 4;
   localparam int LCR_SP  = 5;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_PUSH      = 3'd5,
      S_WAIT_HIGH = 3'd6
   } rx_state_e;

   // acc is the XOR of the received data bits
   function automatic logic exp_parity(logic acc, logic eps, logic sp);
      if (sp)
         return ~eps;
      return eps ? acc : ~acc;
   endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-FIFO push port: one-cycle strobe plus the pushed word.
interface uart_rx_frame_if #(
   parameter int W = uart_defines::UART_FIFO_REC_WIDTH
) ();

   logic         rf_push;
   logic [W-1:0] rf_data_in;

   modport master (output rf_push, output rf_data_in);
   modport slave  (input rf_push, input rf_data_in);

endinterface

// File: rtl/uart_rx_frame_sync2.sv
// Two-flop synchronizer for the serial line; resets to the idle
// (high) level so no false start bit appears after reset.
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: 16x oversampled start/data/parity/stop
// reception producing one FIFO word per character.
module uart_rx_frame
   import uart_defines::*;
#(
   parameter int FIFO_WIDTH = UART_FIFO_REC_WIDTH
) (
   input  logic                    clk,
   input  logic                    wb_rst_i,
   input  logic                    enable,
   input  logic                    srx_pad_i,
   input  logic [7:0]              lcr,
   input  logic                    rx_reset,
   uart_rx_frame_if.master         rf,
   output logic [2:0]              rstate
);

   rx_state_e              state;
   logic                   srx;
   logic [3:0]             cnt;
   logic [2:0]             bitn;
   logic [7:0]             chr;
   logic                   par_acc;
   logic                   ones;
   logic                   pe;
   logic [5:0]             lcr_q;
   logic                   push_q;
   logic [FIFO_WIDTH-1:0]  data_q;
   logic [FIFO_WIDTH-1:0]  word;
   logic [2:0]             last_bit;
   logic                   mid_bit;

   wire unused_lcr = ^{lcr[7:6], lcr_q[2]};

   uart_sync2 u_sync (
      .clk (clk),
      .rst (wb_rst_i),
      .d   (srx_pad_i),
      .q   (srx)
   );

   assign last_bit = 3'd4 + {1'b0, lcr_q[1:0]};
   assign mid_bit  = enable && (cnt == 4'd15);

   // stop bit is sampled in the same cycle the word is captured
   always_comb begin
      word                       = '0;
      word[RF_CHAR_LSB +: 8]     = chr;
      word[RF_PE]                = pe;
      word[RF_FE]                = ~srx;
      word[RF_BI]                = ~ones & ~srx;
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bitn    <= '0;
         chr     <= '0;
         par_acc <= 1'b0;
         ones    <= 1'b0;
         pe      <= 1'b0;
         lcr_q   <= '0;
         push_q  <= 1'b0;
         data_q  <= '0;
      end else if (rx_reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bitn    <= '0;
         chr     <= '0;
         par_acc <= 1'b0;
         ones    <= 1'b0;
         pe      <= 1'b0;
         push_q  <= 1'b0;
      end else begin
         push_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (enable && !srx) begin
                  state   <= S_START;
                  cnt     <= '0;
                  bitn    <= '0;
                  chr     <= '0;
                  par_acc <= 1'b0;
                  ones    <= 1'b0;
                  pe      <= 1'b0;
                  lcr_q   <= lcr[5:0];
               end
            end
            S_START: begin
               if (enable) begin
                  if (cnt == 4'd7) begin
                     cnt   <= '0;
                     state <= srx ? S_IDLE : S_DATA;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (enable)
                  cnt <= cnt + 4'd1;
               if (mid_bit) begin
                  chr[bitn] <= srx;
                  par_acc   <= par_acc ^ srx;
                  ones      <= ones | srx;
                  bitn      <= bitn + 3'd1;
                  if (bitn == last_bit)
                     state <= lcr_q[LCR_PEN] ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (enable)
                  cnt <= cnt + 4'd1;
               if (mid_bit) begin
                  pe    <= srx != exp_parity(par_acc, lcr_q[LCR_EPS],
                                             lcr_q[LCR_SP]);
                  ones  <= ones | srx;
                  state <= S_STOP;
               end
            end
            S_STOP: begin
               if (enable)
                  cnt <= cnt + 4'd1;
               if (mid_bit) begin
                  push_q <= 1'b1;
                  data_q <= word;
                  state  <= S_PUSH;
               end
            end
            S_PUSH: begin
               state <= srx ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
               if (enable && srx)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign rf.rf_push    = push_q;
   assign rf.rf_data_in = data_q;
   assign rstate        = state;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: fixed vectors, corner
// sequences and random frames against a character-level model.
module tb_uart_rx_frame;

   localparam int DIV = 4;
   localparam int BIT = 16 * DIV;

   logic       clk = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic       enable = 1'b0;
   logic       srx_pad_i = 1'b1;
   logic [7:0] lcr = 8'h03;
   logic       rx_reset = 1'b0;
   logic [2:0] rstate;

   uart_rx_frame_if #(.W(11)) rf_if ();

   uart_rx_frame #(.FIFO_WIDTH(11)) dut (
      .clk       (clk),
      .wb_rst_i  (wb_rst_i),
      .enable    (enable),
      .srx_pad_i (srx_pad_i),
      .lcr       (lcr),
      .rx_reset  (rx_reset),
      .rf        (rf_if.master),
      .rstate    (rstate)
   );

   always #5 clk = ~clk;

   initial begin
      int k;
      k = 0;
      forever begin
         @(posedge clk);
         #1;
         enable = (k == DIV - 1);
         k = (k + 1) % DIV;
      end
   end

   int          vectors = 0;
   int          miscompares = 0;
   int          long_push = 0;
   logic [10:0] got[$];
   logic        prev_push = 1'b0;

   always @(negedge clk) begin
      if (rf_if.rf_push) begin
         got.push_back(rf_if.rf_data_in);
         if (prev_push)
            long_push++;
      end
      prev_push = rf_if.rf_push;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      srx_pad_i = b;
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   task automatic idle_gap();
      srx_pad_i = 1'b1;
      repeat (2 * BIT) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] l,
                       input logic pb, input logic sb,
                       input bit scramble);
      int n;
      n = 5 + int'(l[1:0]);
      lcr = l;
      drive_bit(1'b0);
      if (scramble)
         lcr = 8'($urandom);
      for (int i = 0; i < n; i++)
         drive_bit(d[i]);
      if (l[3])
         drive_bit(pb);
      drive_bit(sb);
      idle_gap();
   endtask

   function automatic logic [10:0] ref_word(input logic [7:0] d,
                                            input logic [7:0] l,
                                            input logic pb,
                                            input logic sb);
      int          n;
      int          ones;
      logic [7:0]  ch;
      logic        ep, pe, fe, bi;
      n    = 5 + int'(l[1:0]);
      ch   = d & 8'((1 << n) - 1);
      ones = $countones(ch);
      if (l[5])
         ep = !l[4];
      else if (l[4])
         ep = ones[0];
      else
         ep = !ones[0];
      pe = l[3] && (pb != ep);
      fe = !sb;
      bi = (ch == 8'h00) && (!l[3] || !pb) && !sb;
      return {ch, pe, fe, bi};
   endfunction

   typedef struct {
      logic [7:0]  data;
      logic [7:0]  lcr;
      logic        pb;
      logic        sb;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[8];

   initial begin
      logic [7:0] d, l;
      logic       pb, sb;

      tbl[0] = '{8'hA5, 8'h03, 1'b0, 1'b1, 11'h528};
      tbl[1] = '{8'h55, 8'h1A, 1'b1, 1'b1, 11'h2AC};
      tbl[2] = '{8'hFF, 8'h00, 1'b0, 1'b1, 11'h0F8};
      tbl[3] = '{8'h2A, 8'h09, 1'b0, 1'b1, 11'h150};
      tbl[4] = '{8'h00, 8'h2B, 1'b0, 1'b1, 11'h004};
      tbl[5] = '{8'h00, 8'h03, 1'b0, 1'b1, 11'h000};
      tbl[6] = '{8'h80, 8'h1B, 1'b1, 1'b1, 11'h400};
      tbl[7] = '{8'h00, 8'h3B, 1'b0, 1'b0, 11'h003};

      repeat (5) @(posedge clk);
      #1;
      check("reset_push", rf_if.rf_push, 0);
      check("reset_data", rf_if.rf_data_in, 0);
      check("reset_rstate", rstate, 0);
      wb_rst_i = 1'b0;
      idle_gap();

      for (int i = 0; i < 8; i++) begin
         got.delete();
         send(tbl[i].data, tbl[i].lcr, tbl[i].pb, tbl[i].sb, 1'b0);
         check($sformatf("tbl%0d_count", i), got.size(), 1);
         if (got.size() > 0)
            check($sformatf("tbl%0d_word", i), got[0], tbl[i].exp);
      end

      // stop bit 0 with the line staying low afterwards
      got.delete();
      lcr = 8'h03;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++)
         drive_bit(i == 2 || i == 3 || i == 4 || i == 5);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      check("fe_wait_rstate", rstate, 6);
      idle_gap();
      check("fe_count", got.size(), 1);
      if (got.size() > 0)
         check("fe_word", got[0], 11'h1E2);
      got.delete();
      send(8'h41, 8'h03, 1'b0, 1'b1, 1'b0);
      check("after_fe_count", got.size(), 1);
      if (got.size() > 0)
         check("after_fe_word", got[0], 11'h208);

      // sustained break over three character times
      got.delete();
      srx_pad_i = 1'b0;
      repeat (30 * BIT) @(posedge clk);
      #1;
      check("break_rstate", rstate, 6);
      idle_gap();
      check("break_count", got.size(), 1);
      if (got.size() > 0)
         check("break_word", got[0], 11'h003);

      // 4-tick glitch on the idle line
      got.delete();
      srx_pad_i = 1'b0;
      repeat (4 * DIV) @(posedge clk);
      #1;
      check("glitch_start", rstate, 1);
      idle_gap();
      check("glitch_count", got.size(), 0);
      check("glitch_rstate", rstate, 0);

      // async reset during DATA of 0xFF
      got.delete();
      lcr = 8'h03;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++)
         drive_bit(1'b1);
      check("rst_mid_data", rstate, 2);
      wb_rst_i = 1'b1;
      #3;
      check("rst_async_rstate", rstate, 0);
      check("rst_async_data", rf_if.rf_data_in, 0);
      @(posedge clk);
      #1;
      wb_rst_i = 1'b0;
      for (int i = 0; i < 6; i++)
         drive_bit(1'b1);
      idle_gap();
      check("rst_count", got.size(), 0);
      send(8'h12, 8'h03, 1'b0, 1'b1, 1'b0);
      check("rst_next_count", got.size(), 1);
      if (got.size() > 0)
         check("rst_next_word", got[0], 11'h090);

      // rx_reset during DATA of 0xFF
      got.delete();
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++)
         drive_bit(1'b1);
      check("rxr_mid_data", rstate, 2);
      rx_reset = 1'b1;
      @(posedge clk);
      #1;
      rx_reset = 1'b0;
      check("rxr_rstate", rstate, 0);
      for (int i = 0; i < 6; i++)
         drive_bit(1'b1);
      idle_gap();
      check("rxr_count", got.size(), 0);
      send(8'h12, 8'h03, 1'b0, 1'b1, 1'b0);
      check("rxr_next_count", got.size(), 1);
      if (got.size() > 0)
         check("rxr_next_word", got[0], 11'h090);

      // random frames; lcr is scrambled after the start bit
      for (int i = 0; i < 24; i++) begin
         d  = 8'($urandom);
         l  = 8'($urandom) & 8'h3F;
         pb = 1'($urandom);
         sb = ($urandom_range(0, 3) != 0);
         got.delete();
         send(d, l, pb, sb, 1'b1);
         check($sformatf("rnd%0d_count", i), got.size(), 1);
         if (got.size() > 0)
            check($sformatf("rnd%0d_word", i), got[0],
                  ref_word(d, l, pb, sb));
      end

      check("push_single_cycle", long_push, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
